// File: rtl/pipeline_add_sched.sv
// rtl/pipeline_add_sched.sv - round-robin scheduler sharing one fixed-latency adder, with tagged result FIFO
module pipeline_add_sched #(
   parameter int LS_WIDTH  = 15,
   parameter int MS_WIDTH  = 20,
   parameter int NUM_REQ   = 4,
   parameter int LATENCY   = 2,
   parameter int RES_DEPTH = 4,
   localparam int WIDTH    = LS_WIDTH + MS_WIDTH,
   localparam int ID_W     = $clog2(NUM_REQ)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*WIDTH-1:0]   req_a,
   input  logic [NUM_REQ*WIDTH-1:0]   req_b,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic [WIDTH-1:0]           add_a,
   output logic [WIDTH-1:0]           add_b,
   input  logic [WIDTH-1:0]           add_o,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [ID_W-1:0]            res_id,
   output logic [WIDTH-1:0]           res_sum
);

   localparam int OCC_W = $clog2(RES_DEPTH + LATENCY + 1);
   localparam int CNT_W = $clog2(RES_DEPTH + 1);
   localparam int PTR_W = $clog2(RES_DEPTH);

   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [LATENCY-1:0] tag_v_q, tag_v_d;
   logic [ID_W-1:0]  tag_id_q [LATENCY];
   logic [ID_W-1:0]  tag_id_d [LATENCY];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [WIDTH-1:0] sum_mem [RES_DEPTH];
   logic [ID_W-1:0]  id_mem  [RES_DEPTH];

   logic             found;
   logic [ID_W-1:0]  grant_idx;
   logic [ID_W-1:0]  cand;
   int               pos;
   logic [OCC_W-1:0] inflight;
   logic [OCC_W-1:0] occ;
   logic             issue;
   logic             push;
   logic             pop;

   // Round-robin search: first valid requester at or after rr_ptr, wrapping.
   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      cand      = '0;
      pos       = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         pos = int'(rr_ptr_q) + i;
         if (pos >= NUM_REQ) pos = pos - NUM_REQ;
         cand = pos[ID_W-1:0];
         if (!found && req_valid[cand]) begin
            found     = 1'b1;
            grant_idx = cand;
         end
      end
   end

   // Credit check: in-flight tags plus buffered results must leave room for one more.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < LATENCY; i++) begin
         inflight = inflight + OCC_W'(tag_v_q[i]);
      end
      occ   = inflight + OCC_W'(cnt_q);
      issue = found && (occ < OCC_W'(RES_DEPTH)) && !rst;
   end

   // Grant and operand steering to the shared adder; quiet operands when idle.
   always_comb begin
      req_ready = '0;
      add_a     = '0;
      add_b     = '0;
      if (issue) begin
         req_ready[grant_idx] = 1'b1;
         add_a = req_a[grant_idx*WIDTH +: WIDTH];
         add_b = req_b[grant_idx*WIDTH +: WIDTH];
      end
   end

   // Next-state for pointer, tag pipe and FIFO bookkeeping; head is shown ahead.
   always_comb begin
      push      = tag_v_q[LATENCY-1];
      res_valid = (cnt_q != '0);
      pop       = res_valid && res_ready;
      res_id    = res_valid ? id_mem[rd_ptr_q]  : '0;
      res_sum   = res_valid ? sum_mem[rd_ptr_q] : '0;

      rr_ptr_d = rr_ptr_q;
      if (issue) begin
         rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
      end

      tag_v_d[0]  = issue;
      tag_id_d[0] = grant_idx;
      for (int i = 1; i < LATENCY; i++) begin
         tag_v_d[i]  = tag_v_q[i-1];
         tag_id_d[i] = tag_id_q[i-1];
      end

      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
   end

   // Control state registers; reset drops every in-flight tag and buffered result.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q <= '0;
         tag_v_q  <= '0;
         for (int i = 0; i < LATENCY; i++) tag_id_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         tag_v_q  <= tag_v_d;
         for (int i = 0; i < LATENCY; i++) tag_id_q[i] <= tag_id_d[i];
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Result storage: capture the adder output with its tag as it leaves the pipe.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         sum_mem[wr_ptr_q] <= add_o;
         id_mem[wr_ptr_q]  <= tag_id_q[LATENCY-1];
      end
   end

endmodule

// File: tb/tb_pipeline_add_sched.sv
// tb/tb_pipeline_add_sched.sv - scoreboard bench for pipeline_add_sched with behavioural adder
module tb_pipeline_add_sched;

   localparam int NR   = 4;
   localparam int W    = 35;
   localparam int LAT  = 2;
   localparam int DEP  = 4;
   localparam int ID_W = 2;

   logic              clk;
   logic              rst;
   logic [NR-1:0]     req_valid;
   logic [NR*W-1:0]   req_a;
   logic [NR*W-1:0]   req_b;
   logic [NR-1:0]     req_ready;
   logic [W-1:0]      add_a;
   logic [W-1:0]      add_b;
   logic [W-1:0]      add_o;
   logic              res_valid;
   logic              res_ready;
   logic [ID_W-1:0]   res_id;
   logic [W-1:0]      res_sum;

   typedef struct {
      logic [ID_W-1:0] id;
      logic [W-1:0]    sum;
   } exp_t;

   exp_t        sb[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          act_issue = 0;
   int          rr_ptr_m = 0;
   int          outstanding = 0;
   logic [W-1:0] adder_pipe [LAT];

   pipeline_add_sched #(
      .LS_WIDTH(15), .MS_WIDTH(20), .NUM_REQ(NR), .LATENCY(LAT), .RES_DEPTH(DEP)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
      .add_a(add_a), .add_b(add_b), .add_o(add_o),
      .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_sum(res_sum)
   );

   always #5 clk = ~clk;

   // External adder: fixed-latency register pipe of a+b, never reset.
   always @(posedge clk) begin
      adder_pipe[0] <= add_a + add_b;
      for (int i = 1; i < LAT; i++) adder_pipe[i] <= adder_pipe[i-1];
   end
   assign add_o = adder_pipe[LAT-1];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [NR-1:0] v, input int p);
      for (int k = 0; k < NR; k++) begin
         int idx;
         idx = (p + k) % NR;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic logic [W-1:0] rnd_op();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[W-1:0];
   endfunction

   task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
   endtask

   task automatic rand_ops();
      for (int i = 0; i < NR; i++) set_op(i, rnd_op(), rnd_op());
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int n);
      req_valid = '0;
      res_ready = 1'b1;
      repeat (n) tick();
   endtask

   // Reference arbiter and credit model: grant, operands, and expected result pushed at issue.
   always @(negedge clk) begin
      logic [NR-1:0] exp_rdy;
      logic [W-1:0]  ea, eb;
      int            g;
      exp_rdy = '0;
      ea = '0;
      eb = '0;
      g = -1;
      if (!rst && outstanding < DEP) g = pick(req_valid, rr_ptr_m);
      if (g >= 0) begin
         exp_rdy[g] = 1'b1;
         ea = req_a[g*W +: W];
         eb = req_b[g*W +: W];
      end
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("add_a", 64'(add_a), 64'(ea));
      chk("add_b", 64'(add_b), 64'(eb));
      if (|(req_valid & req_ready)) act_issue++;
      if (rst) begin
         rr_ptr_m = 0;
         outstanding = 0;
         sb.delete();
      end else begin
         if (g >= 0) begin
            sb.push_back('{id: ID_W'(g), sum: ea + eb});
            rr_ptr_m = (g + 1) % NR;
            outstanding++;
         end
         if (res_valid && res_ready) outstanding--;
      end
   end

   // Monitor: every accepted result must match the oldest outstanding issue.
   always @(negedge clk) begin
      if (!rst && res_valid && res_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_result", 64'(res_valid), 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("res_id", 64'(res_id), 64'(e.id));
            chk("res_sum", 64'(res_sum), 64'(e.sum));
         end
      end
   end

   initial begin
      int c0;
      clk = 1'b0;
      rst = 1'b1;
      req_valid = '1;
      res_ready = 1'b1;
      req_a = '0;
      req_b = '0;
      for (int i = 0; i < LAT; i++) adder_pipe[i] = '0;
      rand_ops();

      // Reset: no grant while rst is high, outputs idle after release.
      tick();
      @(negedge clk);
      chk("rst_ready", 64'(req_ready), 64'd0);
      tick();
      rst = 1'b0;
      req_valid = '0;
      @(negedge clk);
      chk("rst_res_valid", 64'(res_valid), 64'd0);
      chk("rst_res_id", 64'(res_id), 64'd0);
      chk("rst_res_sum", 64'(res_sum), 64'd0);
      tick();

      // 1: single requester, three-cycle result.
      req_valid = 4'b0001;
      set_op(0, 35'd5, 35'd7);
      @(negedge clk);
      chk("t1_grant", 64'(req_ready), 64'b0001);
      tick();
      req_valid = '0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         if (k < 3) begin
            chk("t1_not_yet", 64'(res_valid), 64'd0);
         end else begin
            chk("t1_valid", 64'(res_valid), 64'd1);
            chk("t1_id", 64'(res_id), 64'd0);
            chk("t1_sum", 64'(res_sum), 64'd12);
         end
         tick();
      end
      drain(4);

      // 2: all requesters, full rate.
      c0 = act_issue;
      req_valid = '1;
      repeat (12) begin
         rand_ops();
         tick();
      end
      chk("t2_issues", 64'(act_issue - c0), 64'd12);
      drain(8);

      // 3: rotation with sparse valids.
      rand_ops();
      req_valid = 4'b0010;
      @(negedge clk);
      chk("t3_g1", 64'(req_ready), 64'b0010);
      tick();
      req_valid = 4'b1010;
      @(negedge clk);
      chk("t3_g3a", 64'(req_ready), 64'b1000);
      tick();
      @(negedge clk);
      chk("t3_g1b", 64'(req_ready), 64'b0010);
      tick();
      @(negedge clk);
      chk("t3_g3b", 64'(req_ready), 64'b1000);
      tick();
      req_valid = 4'b0010;
      @(negedge clk);
      chk("t3_skip", 64'(req_ready), 64'b0010);
      tick();
      drain(8);

      // 4: backpressure fills exactly RES_DEPTH, then resumes.
      res_ready = 1'b0;
      c0 = act_issue;
      req_valid = '1;
      repeat (10) begin
         rand_ops();
         tick();
      end
      chk("t4_fill", 64'(act_issue - c0), 64'(DEP));
      @(negedge clk);
      chk("t4_stall", 64'(req_ready), 64'd0);
      chk("t4_full", 64'(res_valid), 64'd1);
      tick();
      res_ready = 1'b1;
      c0 = act_issue;
      repeat (12) tick();
      chk("t4_resume", 64'((act_issue - c0) > 0), 64'd1);
      drain(10);

      // 5: carry-out dropped.
      req_valid = 4'b0001;
      set_op(0, 35'h7_FFFF_FFFF, 35'd1);
      tick();
      set_op(0, 35'h4_0000_0000, 35'h4_0000_0000);
      tick();
      set_op(0, 35'h7FFF, 35'd1);
      tick();
      req_valid = '0;
      @(negedge clk);
      chk("t5_wrap_all", 64'(res_sum), 64'd0);
      tick();
      @(negedge clk);
      chk("t5_wrap_msb", 64'(res_sum), 64'd0);
      tick();
      @(negedge clk);
      chk("t5_seg_carry", 64'(res_sum), 64'h8000);
      tick();
      drain(6);

      // 6: reset with two buffered and two in flight.
      res_ready = 1'b0;
      rand_ops();
      req_valid = 4'b0001;
      repeat (2) tick();
      req_valid = '0;
      repeat (3) tick();
      req_valid = 4'b0010;
      repeat (2) tick();
      req_valid = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      res_ready = 1'b1;
      req_valid = 4'b0110;
      @(negedge clk);
      chk("t6_flushed", 64'(res_valid), 64'd0);
      chk("t6_ptr0", 64'(req_ready), 64'b0010);
      tick();
      req_valid = 4'b0100;
      @(negedge clk);
      chk("t6_req2", 64'(req_ready), 64'b0100);
      tick();
      drain(10);
      chk("t6_sb_empty", 64'(sb.size()), 64'd0);

      // Random traffic.
      repeat (3000) begin
         req_valid = NR'($urandom());
         rand_ops();
         res_ready = ($urandom() % 4) != 0;
         tick();
      end
      drain(12);
      chk("rand_sb_empty", 64'(sb.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
